// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM responder: FSM states, access-size
// one-hot bit positions and the size-to-byte-mask decode.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SZ_BYTE   = 0;
  localparam int SZ_HALF   = 1;
  localparam int SZ_WORD   = 2;
  localparam int SZ_DOUBLE = 3;

  // Multi-hot sizes resolve to the largest selected size; zero means byte.
  function automatic logic [3:0] size_resolve(input logic [3:0] op);
    logic [3:0] res;
    res = '0;
    if (op[SZ_DOUBLE])    res[SZ_DOUBLE] = 1'b1;
    else if (op[SZ_WORD]) res[SZ_WORD]   = 1'b1;
    else if (op[SZ_HALF]) res[SZ_HALF]   = 1'b1;
    else                  res[SZ_BYTE]   = 1'b1;
    return res;
  endfunction

  // Right-aligned byte-lane mask covering the access size.
  function automatic logic [7:0] size_mask(input logic [3:0] op);
    logic [3:0] res;
    logic [7:0] mask;
    res = size_resolve(op);
    if (res[SZ_DOUBLE])    mask = 8'hFF;
    else if (res[SZ_WORD]) mask = 8'h0F;
    else if (res[SZ_HALF]) mask = 8'h03;
    else                   mask = 8'h01;
    return mask;
  endfunction

  // Low address bits that must be zero for the access to be size-aligned.
  function automatic logic [2:0] align_bits(input logic [3:0] op);
    logic [7:0] mask;
    mask = size_mask(op);
    return {mask[7], mask[3], mask[1]};
  endfunction

endpackage

// File: rtl/sram_lane_mux.sv
// Combinational lane steering: shifts write data and byte enables up to the
// target lane, and right-aligns/zero-fills read data to the access size.
module sram_lane_mux
  import sram_pkg::*;
(
  input  logic [63:0] wdata,
  input  logic [3:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] rword,
  output logic [63:0] lane_wdata,
  output logic [7:0]  lane_be,
  output logic [63:0] rdata
);

  logic [7:0]  mask;
  logic [63:0] bit_mask;
  logic [5:0]  shamt;

  always_comb begin
    mask  = size_mask(size);
    shamt = {offset, 3'b000};
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{mask[i]}};
    end
    lane_wdata = wdata << shamt;
    lane_be    = mask << offset;
    rdata      = (rword >> shamt) & bit_mask;
  end

endmodule

// File: rtl/sram_responder.sv
// Fixed-latency SRAM responder with valid/ready request and response channels.
// Optional access fault checking is enabled by defining SRAM_ADDR_CHECK_EN.
module sram_responder
  import sram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          DEPTH      = 4096,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wdt_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic LAT1 = (LATENCY == 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cur_wen;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [3:0]            cur_op;

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic [2:0]            align;
  logic [2:0]            lane;
  logic                  accept;
  logic                  commit;
  logic                  fault;

  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [7:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LAT1 ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the live request is used so a single-cycle latency can commit on
  // the handshake edge itself; afterwards the latched copy is used.
  always_comb begin
    cur_wen   = wen_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_op    = op_q;
    if (state == IDLE) begin
      cur_wen   = req_wen;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_op    = req_wdt_op;
    end
  end

  // BASE_ADDR is word-aligned, so off[2:0] equals the address lane bits.
  assign off    = cur_addr - BASE;
  assign idx    = off[IDX_W+2:3];
  assign align  = align_bits(cur_op);
  assign lane   = off[2:0] & ~align;
  assign accept = (state == IDLE) && req_valid;
  assign commit = rst && (LAT1 ? accept : ((state == WAIT) && (cnt == CNT_W'(1))));
  assign rword  = mem[idx];

`ifdef SRAM_ADDR_CHECK_EN
  assign fault = (cur_addr < BASE)
              || (off[ADDR_WIDTH-1:IDX_W+3] != '0)
              || ((off[2:0] & align) != 3'b000)
              || (cur_op == 4'd0)
              || ((cur_op & (cur_op - 4'd1)) != 4'd0);
`else
  logic unused_bits;
  assign fault       = 1'b0;
  assign unused_bits = ^off[ADDR_WIDTH-1:IDX_W+3];
`endif

  sram_lane_mux u_lane_mux (
    .wdata      (cur_wdata),
    .size       (cur_op),
    .offset     (lane),
    .rword      (rword),
    .lane_wdata (lane_wdata),
    .lane_be    (lane_be),
    .rdata      (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        op_q    <= req_wdt_op;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        err_q   <= fault;
        rdata_q <= (cur_wen || fault) ? '0 : lane_rdata;
      end
    end
  end

  // NOTE: the storage array is deliberately left without a reset; contents
  // must survive rst, and a reset on a RAM would also block RAM inference.
  always_ff @(posedge clk) begin
    if (commit && cur_wen && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_be[i]) mem[idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// traffic compared against a byte-level memory model kept in the bench.
module tb_sram_responder;

  localparam int          AW    = 64;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [3:0]    req_wdt_op;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_rdata;
  logic          resp_err;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    bit          stable;
    bit          busy_ok;
    bit          idle_after;
  } res_t;

  logic [63:0] mdl [DEPTH];
  int checks = 0;
  int errors = 0;

  sram_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (64),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wdt_op (req_wdt_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic int size_bytes(input logic [3:0] op);
    if (op[3]) return 8;
    if (op[2]) return 4;
    if (op[1]) return 2;
    return 1;
  endfunction

  // Reference behaviour: byte-addressed view of the word array.
  task automatic model_access(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [3:0] op, output logic [63:0] rdata, output logic err);
    logic [63:0] rel;
    int n;
    int widx;
    int ofs;
    rel   = addr - BASE;
    n     = size_bytes(op);
    widx  = int'((rel >> 3) % DEPTH);
    ofs   = (int'(rel % 8) / n) * n;
    rdata = '0;
    err   = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    if (addr < BASE || addr >= BASE + 64'(8 * DEPTH) || !$onehot(op) || (addr % 64'(n)) != 0)
      err = 1'b1;
`endif
    if (!err) begin
      for (int b = 0; b < n; b++) begin
        if (wen) mdl[widx][(ofs + b) * 8 +: 8] = wdata[b * 8 +: 8];
        else     rdata[b * 8 +: 8] = mdl[widx][(ofs + b) * 8 +: 8];
      end
    end
  endtask

  // One request/response exchange; resp_ready held low for 'hold' cycles.
  task automatic run_txn(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [3:0] op, input int hold, output res_t r);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wdt_op = op;
    resp_ready = 1'b0;
    r.busy_ok  = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r.lat     = 1;
    while (!resp_valid && r.lat < 20) begin
      if (req_ready !== 1'b0) r.busy_ok = 1'b0;
      @(posedge clk);
      #1;
      r.lat++;
    end
    if (!resp_valid) r.lat = -1;
    r.rdata  = resp_rdata;
    r.err    = resp_err;
    r.stable = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_rdata !== r.rdata || resp_err !== r.err) r.stable = 1'b0;
      if (req_ready !== 1'b0) r.busy_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready   = 1'b0;
    r.idle_after = (req_ready === 1'b1) && (resp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wdt_op = '0;
    resp_ready = 1'b0;
    #1 rst = 1'b0;
    #10;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b rdata=%h err=%b exp 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_init();
    res_t r;
    logic [63:0] d, er;
    logic ee;
    for (int w = 0; w < 16; w++) begin
      d = {$urandom, $urandom} | 64'h0101_0101_0101_0101;
      model_access(1'b1, BASE + 64'(w * 8), d, 4'b1000, er, ee);
      run_txn(1'b1, BASE + 64'(w * 8), d, 4'b1000, 0, r);
      checks++;
      if (r.rdata !== er || r.err !== ee || r.lat != LAT) begin
        errors++;
        $display("FAIL init_write w=%0d got rdata=%h err=%b lat=%0d exp %h/%b/%0d", w, r.rdata, r.err, r.lat, er, ee, LAT);
      end
    end
  endtask

  task automatic test_double_rw();
    res_t r;
    logic [63:0] er;
    logic ee;
    model_access(1'b1, BASE + 64'h10, 64'h1122334455667788, 4'b1000, er, ee);
    run_txn(1'b1, BASE + 64'h10, 64'h1122334455667788, 4'b1000, 0, r);
    checks++;
    if (r.rdata !== 64'd0 || r.err !== 1'b0 || r.lat != LAT) begin
      errors++;
      $display("FAIL dbl_write got rdata=%h err=%b lat=%0d exp 0/0/%0d", r.rdata, r.err, r.lat, LAT);
    end
    model_access(1'b0, BASE + 64'h10, 64'd0, 4'b1000, er, ee);
    run_txn(1'b0, BASE + 64'h10, 64'd0, 4'b1000, 0, r);
    checks++;
    if (r.rdata !== 64'h1122334455667788 || r.err !== 1'b0 || r.lat != LAT) begin
      errors++;
      $display("FAIL dbl_read got rdata=%h err=%b lat=%0d exp 1122334455667788/0/%0d", r.rdata, r.err, r.lat, LAT);
    end
  endtask

  task automatic test_byte_merge();
    res_t r;
    logic [63:0] er;
    logic ee;
    model_access(1'b1, BASE + 64'h13, 64'hAB, 4'b0001, er, ee);
    run_txn(1'b1, BASE + 64'h13, 64'hAB, 4'b0001, 0, r);
    checks++;
    if (r.rdata !== 64'd0 || r.err !== 1'b0) begin
      errors++;
      $display("FAIL byte_write got rdata=%h err=%b exp 0/0", r.rdata, r.err);
    end
    model_access(1'b0, BASE + 64'h10, 64'd0, 4'b0100, er, ee);
    run_txn(1'b0, BASE + 64'h10, 64'd0, 4'b0100, 0, r);
    // Lane 3 of 0x1122334455667788 held 0x55; lanes 0..3 now read 88 77 66 AB.
    checks++;
    if (r.rdata !== 64'h0000_0000_AB66_7788 || r.err !== 1'b0) begin
      errors++;
      $display("FAIL word_read got rdata=%h err=%b exp 00000000ab667788/0", r.rdata, r.err);
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    logic [63:0] er;
    logic ee;
    model_access(1'b0, BASE + 64'h28, 64'd0, 4'b1000, er, ee);
    run_txn(1'b0, BASE + 64'h28, 64'd0, 4'b1000, 5, r);
    checks++;
    if (r.rdata !== er || !r.stable) begin
      errors++;
      $display("FAIL hold_stable got rdata=%h stable=%b exp %h/1", r.rdata, r.stable, er);
    end
    checks++;
    if (!r.busy_ok || !r.idle_after) begin
      errors++;
      $display("FAIL hold_ready got busy_ok=%b idle_after=%b exp 1/1", r.busy_ok, r.idle_after);
    end
  endtask

  // Requests offered continuously with resp_ready high: one access per LAT+1 cycles.
  task automatic test_back_to_back();
    logic [63:0] er;
    logic ee;
    bit exp_ready, exp_valid;
    model_access(1'b0, BASE + 64'h38, 64'd0, 4'b1000, er, ee);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_addr   = BASE + 64'h38;
    req_wdt_op = 4'b1000;
    resp_ready = 1'b1;
    for (int n = 0; n < 3 * (LAT + 1); n++) begin
      exp_ready = (n % (LAT + 1)) == 0;
      exp_valid = (n % (LAT + 1)) == LAT;
      checks++;
      if (req_ready !== exp_ready || resp_valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_cycle n=%0d got ready=%b valid=%b exp %b/%b", n, req_ready, resp_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (resp_rdata !== er) begin
          errors++;
          $display("FAIL b2b_rdata n=%0d got %h exp %h", n, resp_rdata, er);
        end
      end
      if (n == 3 * (LAT + 1) - 1) req_valid = 1'b0;
      @(negedge clk);
    end
    resp_ready = 1'b0;
  endtask

  // Range edges, misalignment and odd size encodings; expectations follow
  // the model for whichever build is compiled.
  task automatic test_boundary();
    res_t r;
    logic [63:0] er;
    logic ee;
    logic [63:0] addrs [6];
    logic [3:0]  ops   [6];
    bit          wens  [6];
    addrs[0] = BASE + 64'(8 * (DEPTH - 1)); ops[0] = 4'b1000; wens[0] = 1'b1;
    addrs[1] = 64'h7FFF_FFF8;               ops[1] = 4'b1000; wens[1] = 1'b1;
    addrs[2] = BASE + 64'(8 * (DEPTH - 1)); ops[2] = 4'b1000; wens[2] = 1'b0;
    addrs[3] = BASE + 64'h11;               ops[3] = 4'b0010; wens[3] = 1'b0;
    addrs[4] = BASE + 64'h15;               ops[4] = 4'b0000; wens[4] = 1'b0;
    addrs[5] = BASE + 64'h16;               ops[5] = 4'b0110; wens[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      model_access(wens[i], addrs[i], d, ops[i], er, ee);
      run_txn(wens[i], addrs[i], d, ops[i], 0, r);
      checks++;
      if (r.rdata !== er || r.err !== ee || r.lat != LAT) begin
        errors++;
        $display("FAIL boundary i=%0d got rdata=%h err=%b lat=%0d exp %h/%b/%0d", i, r.rdata, r.err, r.lat, er, ee, LAT);
      end
    end
`ifdef SRAM_ADDR_CHECK_EN
    run_txn(1'b0, BASE + 64'h11, 64'd0, 4'b0010, 0, r);
    checks++;
    if (r.err !== 1'b1 || r.rdata !== 64'd0) begin
      errors++;
      $display("FAIL misaligned_half got err=%b rdata=%h exp 1/0", r.err, r.rdata);
    end
`endif
  endtask

  task automatic test_random();
    res_t r;
    logic [63:0] er, addr, d;
    logic ee;
    logic [3:0] op;
    bit wen;
    int alias_k;
    for (int i = 0; i < 60; i++) begin
      wen     = 1'($urandom_range(0, 1));
      op      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'b0001 << $urandom_range(0, 3);
      alias_k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      addr    = BASE + 64'(alias_k * 8 * DEPTH) + 64'($urandom_range(0, 127));
      d       = {$urandom, $urandom};
      model_access(wen, addr, d, op, er, ee);
      run_txn(wen, addr, d, op, int'($urandom_range(0, 2)), r);
      checks++;
      if (r.rdata !== er || r.err !== ee || r.lat != LAT || !r.stable) begin
        errors++;
        $display("FAIL random i=%0d wen=%b addr=%h op=%b got rdata=%h err=%b lat=%0d exp %h/%b/%0d",
                 i, wen, addr, op, r.rdata, r.err, r.lat, er, ee, LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    logic [63:0] er;
    logic ee;
    model_access(1'b0, BASE + 64'h20, 64'd0, 4'b1000, er, ee);
    run_txn(1'b0, BASE + 64'h20, 64'd0, 4'b1000, 0, r);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_addr   = BASE + 64'h20;
    req_wdata  = 64'hFF;
    req_wdt_op = 4'b1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got %b exp 1", req_ready);
    end
    model_access(1'b0, BASE + 64'h20, 64'd0, 4'b1000, er, ee);
    run_txn(1'b0, BASE + 64'h20, 64'd0, 4'b1000, 0, r);
    checks++;
    if (r.rdata !== er || r.err !== 1'b0 || r.lat != LAT) begin
      errors++;
      $display("FAIL midreset_dropped got rdata=%h err=%b lat=%0d exp %h/0/%0d", r.rdata, r.err, r.lat, er, LAT);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_double_rw();
    test_byte_merge();
    test_backpressure();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
